// File: rtl/k005297_dleval_gen.sv
// ============================================================================
// Module   : k005297_dleval_gen
// Brief    : Data-length evaluator. Counts lane-group bit strobes up to the
//            boot/page effective length, then launches the SUPBD phase.
//            Optional factory short-test input enabled by DLEVAL_TST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module k005297_dleval_gen #(
    parameter int CNT_W    = 10,
    parameter int BOOT_LEN = 480,
    parameter int PAGE_LEN = 512
) (
    input  logic             i_MCLK,
    input  logic             i_SYS_RST,
    input  logic             i_CLK2M_PCEN_n,
    input  logic [1:0]       i_LANE_SEL,
    input  logic             i_UMODE_n,
    input  logic             i_START,
    input  logic             i_BIT_STB,
    input  logic             i_BYTEACQ_DONE,
    input  logic             i_SUPBD_END_n,
`ifdef DLEVAL_TST_EN
    input  logic             i_TST,
`endif
    output logic [CNT_W-1:0] o_DLCNT,
    output logic             o_BUSY,
    output logic             o_EFFBD_DONE,
    output logic             o_SUPBD_START_n
);

    // One spare bit so the sum of count and step can never alias below target.
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] C_BOOT_TGT = SUM_W'(BOOT_LEN);
    localparam logic [SUM_W-1:0] C_PAGE_TGT = SUM_W'(PAGE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_BYTE = 2'd2,
        ST_SUPBD     = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       step_q;
    logic             mode_q;
    logic             done_q;
    logic             start_n_q;

    logic [SUM_W-1:0] cnt_sum_d;
    logic [SUM_W-1:0] target_d;
    logic             reach_d;

    function automatic logic [2:0] lane_step(input logic [1:0] sel);
        case (sel)
            2'b00:   lane_step = 3'd1;
            2'b10:   lane_step = 3'd4;
            default: lane_step = 3'd2;
        endcase
    endfunction

    always_comb begin
        cnt_sum_d = {1'b0, cnt_q} + SUM_W'(step_q);
        target_d  = mode_q ? C_BOOT_TGT : C_PAGE_TGT;
        reach_d   = (cnt_sum_d >= target_d);
    end

    always_ff @(posedge i_MCLK) begin
        if (i_SYS_RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_q    <= 3'd1;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            start_n_q <= 1'b1;
        end else if (!i_CLK2M_PCEN_n) begin
            start_n_q <= 1'b1;
            // START restarts from any state and swallows a coincident strobe.
            if (i_START) begin
                state_q <= ST_RUN;
                step_q  <= lane_step(i_LANE_SEL);
                mode_q  <= i_UMODE_n;
                cnt_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_RUN: begin
`ifdef DLEVAL_TST_EN
                        if (i_TST) begin
                            done_q  <= 1'b1;
                            state_q <= ST_WAIT_BYTE;
                        end else
`endif
                        if (i_BIT_STB) begin
                            cnt_q <= cnt_sum_d[CNT_W-1:0];
                            if (reach_d) begin
                                done_q  <= 1'b1;
                                state_q <= ST_WAIT_BYTE;
                            end
                        end
                    end
                    ST_WAIT_BYTE: begin
                        if (i_BYTEACQ_DONE) begin
                            start_n_q <= 1'b0;
                            state_q   <= ST_SUPBD;
                        end
                    end
                    ST_SUPBD: begin
                        if (!i_SUPBD_END_n) begin
                            done_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_DLCNT         = cnt_q;
    assign o_BUSY          = (state_q != ST_IDLE);
    assign o_EFFBD_DONE    = done_q;
    assign o_SUPBD_START_n = start_n_q;

endmodule

`default_nettype wire
